// File: rtl/mem_resp_pkg.sv
// Shared FSM encoding and latency limits for the miss responder.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int LATENCY_DEFAULT = 3;
   localparam int LATENCY_MAX     = 15;
   localparam int CNT_W           = 4;

   // A latency of 0 is treated as 1; anything beyond the counter range saturates.
   function automatic int eff_latency(input int lat);
      if (lat < 1)
         return 1;
      else if (lat > LATENCY_MAX)
         return LATENCY_MAX;
      else
         return lat;
   endfunction

endpackage

// File: rtl/mem_resp_array.sv
// Synchronous single-port byte-enabled RAM; read data registered on a read access.
module mem_resp_array #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [3:0]            be,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wdata,
   output logic [31:0]           rdata
);

   logic [31:0] mem [2**ADDR_WIDTH];

   // Contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (en) begin
         if (we) begin
            for (int i = 0; i < 4; i++) begin
               if (be[i])
                  mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end else begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: rtl/mem_miss_responder.sv
// Fixed-latency memory responder for cache line fills and writebacks.
// One request at a time; req_ready only in IDLE, completion is a one-cycle resp_valid.
module mem_miss_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_WIDTH = 10,
   parameter int LATENCY    = LATENCY_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        busy
);

   localparam int               EFF_LAT  = eff_latency(LATENCY);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EFF_LAT - 1);

   state_t                  state;
   logic [CNT_W-1:0]        cnt;
   logic                    cap_write;
   logic [ADDR_WIDTH-1:0]   cap_idx;
   logic [31:0]             cap_wdata;
   logic [3:0]              cap_be;
   logic [31:0]             rdata_hold;
   logic [31:0]             ram_rdata;
   logic                    ram_en;
   logic                    unused_addr_bits;

   assign unused_addr_bits = ^{req_addr[31:ADDR_WIDTH+2], req_addr[1:0]};

   // The array is touched only on the final WAIT edge, so a reset before then drops the write.
   assign ram_en = (state == WAIT) && (cnt == '0);

   mem_resp_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk   (clk),
      .en    (ram_en),
      .we    (cap_write),
      .be    (cap_be),
      .addr  (cap_idx),
      .wdata (cap_wdata),
      .rdata (ram_rdata)
   );

   // RAM output is only meaningful in RESP; elsewhere the last response is held.
   assign resp_rdata = (state == RESP) ? (cap_write ? 32'd0 : ram_rdata) : rdata_hold;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         busy       <= 1'b0;
         resp_valid <= 1'b0;
         rdata_hold <= '0;
         cap_write  <= 1'b0;
         cap_idx    <= '0;
         cap_wdata  <= '0;
         cap_be     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  cap_write <= req_write;
                  cap_idx   <= req_addr[ADDR_WIDTH+1:2];
                  cap_wdata <= req_wdata;
                  cap_be    <= req_be;
                  cnt       <= CNT_LOAD;
                  state     <= WAIT;
                  req_ready <= 1'b0;
                  busy      <= 1'b1;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
               end
            end
            RESP: begin
               rdata_hold <= resp_rdata;
               resp_valid <= 1'b0;
               busy       <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
            default: begin
               state      <= IDLE;
               resp_valid <= 1'b0;
               busy       <= 1'b0;
               req_ready  <= 1'b1;
            end
         endcase
      end
   end

endmodule
